// File: rtl/iod_ref_clk_train_ctrl.sv
// IOD reference-clock training: sweeps the delay line from tap 0 upward and
// reports the first LOW->HIGH transition. Optional eye monitor: IOD_TRAIN_EYE_MON_EN.
module iod_ref_clk_train_ctrl #(
    parameter int MAX_TAPS      = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic       FAB_CLK,
    input  logic       SYNC_RST,
    input  logic       START,
    input  logic [7:0] RX_DATA_0,
    input  logic       EYE_MONITOR_EARLY_0,
    input  logic       EYE_MONITOR_LATE_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       EYE_MONITOR_CLEAR_FLAGS_0,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [7:0] TAP_RESULT
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]  TAP_LAST    = 8'(MAX_TAPS);
    localparam logic [11:0] HIGH_THRESH = 12'(4 * SAMPLE_CYCLES);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SETTLE,
        CLEAR,
        SAMPLE,
        EVAL,
        MOVE,
        DONE_S,
        FAIL_S
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [11:0] r_acc;
    logic [7:0]  r_tap;
    logic        r_prev_high;
    logic        r_prev_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_fail;
    logic [7:0]  r_tap_result;

    logic [3:0]  w_pop;
    logic        w_high;
    logic        w_edge;
    logic        w_active;
    logic        w_abort;
    logic        w_cnt_last;
    logic        w_load;
    logic        w_move;
    logic        w_clear;

`ifdef IOD_TRAIN_EYE_MON_EN
    logic r_eye_flag;
`else
    logic w_unused_eye;
    assign w_unused_eye = EYE_MONITOR_EARLY_0 | EYE_MONITOR_LATE_0;
`endif

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'd0, RX_DATA_0[i]};
        end
    end

    // Strictly more than half the sampled bits set counts as HIGH.
    assign w_high = (r_acc > HIGH_THRESH);

`ifdef IOD_TRAIN_EYE_MON_EN
    assign w_edge = (r_prev_valid && !r_prev_high && w_high)
                  || (r_eye_flag && w_high);
`else
    assign w_edge = r_prev_valid && !r_prev_high && w_high;
`endif

    assign w_active = (r_state != IDLE)
                   && (r_state != DONE_S)
                   && (r_state != FAIL_S);
    assign w_abort  = w_active && DELAY_LINE_OUT_OF_RANGE_0;

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_move     = 1'b0;
        w_clear    = 1'b0;
        w_cnt_last = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (START) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_load = 1'b1;
                w_next = SETTLE;
            end
            SETTLE: begin
                w_cnt_last = (r_cnt == SETTLE_LAST);
                if (w_cnt_last) begin
`ifdef IOD_TRAIN_EYE_MON_EN
                    w_next = CLEAR;
`else
                    w_next = SAMPLE;
`endif
                end
            end
            CLEAR: begin
`ifdef IOD_TRAIN_EYE_MON_EN
                w_clear = 1'b1;
`endif
                w_next = SAMPLE;
            end
            SAMPLE: begin
                w_cnt_last = (r_cnt == SAMPLE_LAST);
                if (w_cnt_last) begin
                    w_next = EVAL;
                end
            end
            EVAL: begin
                if (w_edge) begin
                    w_next = DONE_S;
                end else if (r_tap == TAP_LAST) begin
                    w_next = FAIL_S;
                end else begin
                    w_next = MOVE;
                end
            end
            MOVE: begin
                w_move = 1'b1;
                w_next = SETTLE;
            end
            DONE_S:  w_next = IDLE;
            FAIL_S:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // A delay line at its limit ends the sweep ahead of any edge decision.
        if (w_abort) begin
            w_next = FAIL_S;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_cnt        <= 8'd0;
            r_acc        <= 12'd0;
            r_tap        <= 8'd0;
            r_prev_high  <= 1'b0;
            r_prev_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_tap_result <= 8'd0;
`ifdef IOD_TRAIN_EYE_MON_EN
            r_eye_flag   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (START) begin
                        r_cnt        <= 8'd0;
                        r_acc        <= 12'd0;
                        r_tap        <= 8'd0;
                        r_prev_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_fail       <= 1'b0;
`ifdef IOD_TRAIN_EYE_MON_EN
                        r_eye_flag   <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    r_cnt <= w_cnt_last ? 8'd0 : r_cnt + 8'd1;
                end
                SAMPLE: begin
                    r_cnt <= w_cnt_last ? 8'd0 : r_cnt + 8'd1;
                    r_acc <= r_acc + {8'd0, w_pop};
`ifdef IOD_TRAIN_EYE_MON_EN
                    if (EYE_MONITOR_EARLY_0 || EYE_MONITOR_LATE_0) begin
                        r_eye_flag <= 1'b1;
                    end
`endif
                end
                EVAL: begin
                    r_acc <= 12'd0;
`ifdef IOD_TRAIN_EYE_MON_EN
                    r_eye_flag <= 1'b0;
`endif
                    if (!w_abort) begin
                        if (w_edge) begin
                            r_tap_result <= r_tap;
                        end else if (r_tap != TAP_LAST) begin
                            r_prev_high  <= w_high;
                            r_prev_valid <= 1'b1;
                        end
                    end
                end
                MOVE: begin
                    if (r_tap != 8'hFF) begin
                        r_tap <= r_tap + 8'd1;
                    end
                end
                DONE_S: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                FAIL_S: begin
                    r_fail <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign DELAY_LINE_LOAD_0         = w_load;
    assign DELAY_LINE_MOVE_0         = w_move;
    assign DELAY_LINE_DIRECTION_0    = w_move;
    assign EYE_MONITOR_CLEAR_FLAGS_0 = w_clear;
    assign BUSY                      = r_busy;
    assign DONE                      = r_done;
    assign FAIL                      = r_fail;
    assign TAP_RESULT                = r_tap_result;

endmodule

// File: tb/tb_iod_ref_clk_train_ctrl.sv
// Bench for iod_ref_clk_train_ctrl: behavioural delay line driving RX data
// from LOAD/MOVE pulses, table-driven sweeps plus abort/reset/START sequences.
module tb_iod_ref_clk_train_ctrl;

    localparam int MAXT = 10;
    localparam int SETL = 3;
    localparam int SAMP = 4;
`ifdef IOD_TRAIN_EYE_MON_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int PER_TAP = SETL + SAMP + 1 + EXTRA;
    localparam int NEVER   = 999;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] rx;
    logic       early;
    logic       late;
    logic       oor;
    logic       load;
    logic       move;
    logic       dir;
    logic       clr;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] tap_res;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_load   = 0;
    int         n_move   = 0;
    int         n_clr    = 0;
    int         n_viol   = 0;
    int         mtap     = 0;
    int         cur_edge = NEVER;
    logic [7:0] cur_lo   = 8'h00;
    logic [7:0] cur_hi   = 8'h00;

    iod_ref_clk_train_ctrl #(
        .MAX_TAPS     (MAXT),
        .SETTLE_CYCLES(SETL),
        .SAMPLE_CYCLES(SAMP)
    ) dut (
        .FAB_CLK                  (clk),
        .SYNC_RST                 (rst),
        .START                    (start),
        .RX_DATA_0                (rx),
        .EYE_MONITOR_EARLY_0      (early),
        .EYE_MONITOR_LATE_0       (late),
        .DELAY_LINE_OUT_OF_RANGE_0(oor),
        .DELAY_LINE_LOAD_0        (load),
        .DELAY_LINE_MOVE_0        (move),
        .DELAY_LINE_DIRECTION_0   (dir),
        .EYE_MONITOR_CLEAR_FLAGS_0(clr),
        .BUSY                     (busy),
        .DONE                     (done),
        .FAIL                     (fail),
        .TAP_RESULT               (tap_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay line model: LOAD returns to tap 0, each MOVE steps one tap up.
    always @(posedge clk) begin
        if (load) begin
            n_load <= n_load + 1;
            mtap   <= 0;
        end
        if (move) begin
            n_move <= n_move + 1;
            mtap   <= mtap + 1;
        end
        if (clr) begin
            n_clr <= n_clr + 1;
        end
    end

    always @(negedge clk) begin
        if (dir !== move) n_viol <= n_viol + 1;
        else if ((32'(load) + 32'(move) + 32'(clr)) > 1) n_viol <= n_viol + 1;
    end

    assign rx = (mtap >= cur_edge) ? cur_hi : cur_lo;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         edge_tap;
        bit         eye;
        bit         exp_done;
        int         exp_tap;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, int'({load, move, dir, clr, busy, done, fail, tap_res}), 0);
    endtask

    task automatic wait_end(input string nm, output int cyc);
        bit hit;
        hit = 0;
        cyc = 0;
        while (!hit && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (done || fail) hit = 1;
        end
        chk({nm, "_timeout"}, int'(hit), 1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int l0, m0, c0, v0, cyc, k, lat;
        cur_lo   = v.lo;
        cur_hi   = v.hi;
        cur_edge = v.edge_tap;
        early    = v.eye;
        l0 = n_load;
        m0 = n_move;
        c0 = n_clr;
        v0 = n_viol;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, int'({busy, done, fail}), 4);
        wait_end(nm, cyc);
        early = 1'b0;
        k   = v.exp_done ? v.exp_tap : MAXT;
        lat = 2 + (k + 1) * PER_TAP + k;
        chk({nm, "_done"}, int'(done), int'(v.exp_done));
        chk({nm, "_fail"}, int'(fail), int'(!v.exp_done));
        chk({nm, "_busy_end"}, int'(busy), 0);
        if (v.exp_done) chk({nm, "_tap"}, int'(tap_res), v.exp_tap);
        chk({nm, "_latency"}, cyc, lat);
        @(negedge clk);
        chk({nm, "_loads"}, n_load - l0, 1);
        chk({nm, "_moves"}, n_move - m0, k);
        chk({nm, "_clears"}, n_clr - c0, EXTRA * (k + 1));
        chk({nm, "_pulse_rules"}, n_viol - v0, 0);
    endtask

    initial begin
        int m0, l0, l1, m1, cyc, guard;

        vecs[0] = '{8'h00, 8'hFF, 5,     1'b0, 1'b1, 5};
        vecs[1] = '{8'h0F, 8'h1F, 1,     1'b0, 1'b1, 1};
        vecs[2] = '{8'h00, 8'h00, NEVER, 1'b0, 1'b0, 0};
        vecs[3] = '{8'hFF, 8'hFF, 0,     1'b0, 1'b0, 0};
        vecs[4] = '{8'h00, 8'hFF, MAXT,  1'b0, 1'b1, MAXT};
        vecs[5] = '{8'hF0, 8'hFF, 1,     1'b1, 1'b1, 1};
`ifdef IOD_TRAIN_EYE_MON_EN
        vecs[6] = '{8'hFF, 8'hFF, 0,     1'b1, 1'b1, 0};
`else
        vecs[6] = '{8'hFF, 8'hFF, 0,     1'b1, 1'b0, 0};
`endif
        vecs[7] = '{8'h0F, 8'hFF, 3,     1'b0, 1'b1, 3};

        rst   = 1'b1;
        start = 1'b0;
        early = 1'b0;
        late  = 1'b0;
        oor   = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("reset_after_done");

        // Out-of-range during tap 3 settle.
        cur_lo = 8'h00; cur_hi = 8'h00; cur_edge = NEVER;
        m0 = n_move;
        l0 = n_load;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (n_move - m0 < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("oor_reach_tap3", n_move - m0, 3);
        oor = 1'b1;
        @(negedge clk);
        oor = 1'b0;
        chk("oor_fail_lag", int'(fail), 0);
        @(negedge clk);
        chk("oor_status", int'({busy, done, fail}), 1);
        repeat (20) @(negedge clk);
        chk("oor_moves", n_move - m0, 3);
        chk("oor_loads", n_load - l0, 1);

        // Reset in the middle of tap 2 sampling.
        cur_lo = 8'h00; cur_hi = 8'hFF; cur_edge = 4;
        m0 = n_move;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (n_move - m0 < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (SETL) @(negedge clk);
        chk("midrst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst_outputs");
        rst = 1'b0;
        l1 = n_load;
        m1 = n_move;
        repeat (15) @(negedge clk);
        chk("midrst_quiet", (n_load - l1) + (n_move - m1), 0);
        run_vec('{8'h00, 8'hFF, 2, 1'b0, 1'b1, 2}, "after_rst");

        // START held three cycles, then pulsed again while busy.
        cur_lo = 8'h00; cur_hi = 8'hFF; cur_edge = 1;
        l0 = n_load;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("hold", cyc);
        chk("hold_done", int'({done, fail}), 2);
        chk("hold_tap", int'(tap_res), 1);
        repeat (10) @(negedge clk);
        chk("hold_loads", n_load - l0, 1);
        chk("hold_idle", int'({busy, done}), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
